ascon_linear_seq: RTL and testbench
===================================

// Module: ascon_linear_seq
// PURPOSE
//  Sequencer for the Ascon linear diffusion layer over a full 320-bit state (x0..x4).
//  Accepts a state on a valid/ready input channel and applies sigma_i to word x_i:
//  x ^ ROTR(x,a_i) ^ ROTR(x,b_i). Uses LANES shared sigma units, one word per lane per cycle.
//  Returns the diffused state on a valid/ready output channel.
//  Sits between the permutation-round control and the substitution-layer output.
// PARAMETERS
//  LANES    1   sigma units instantiated; legal values 1 (5 cycles/state) or 5 (1 cycle/state)
// PORTS
//  clk        in   1    clock; all state changes on rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    in_state is valid
//  in_ready   out  1    block can accept a state (high only in IDLE)
//  in_state   in   320  x_i = in_state[64*i +: 64], i=0..4
//  out_valid  out  1    out_state holds the completed result
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  320  sigma_i(x_i) in the same word packing
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. rst forces IDLE, clears word
//    counter and buffer to 0. After reset: in_ready=1, out_valid=0, busy=0, out_state=0.
//  - Rotation table (6-bit amounts, rotate right): i0:19,28 i1:61,39 i2:1,6 i3:10,17 i4:7,41.
//  - FSM: IDLE -> RUN on (in_valid & in_ready): load buffer <= in_state, cnt <= 0.
//    RUN (LANES=1): each cycle buf[cnt] <= sigma_cnt(buf[cnt]), cnt++; after cnt==4 -> DONE.
//    RUN (LANES=5): all five words updated in one cycle -> DONE.
//    DONE: out_valid=1, out_state=buf; on out_ready -> IDLE (in_ready=1 next cycle).
//  - Latency in_valid handshake -> out_valid: 5 cycles (LANES=1), 1 cycle (LANES=5).
//    Throughput: one state per 5/LANES + 2 cycles minimum (load, RUN, DONE/hand-off).
//  - out_state stable and out_valid held while DONE and !out_ready; no re-compute.
//  - in_valid while not IDLE: ignored (in_ready=0); no state captured.
//  - out_ready while not DONE: ignored. in_valid and out_ready both high in DONE: only
//    output hand-off occurs; new input is accepted in the following IDLE cycle.
//  - cnt is 3 bits; values 5-7 unreachable; if reached, treated as DONE transition.
//  - rst asserted mid-RUN or in DONE: result discarded, no out_valid pulse, IDLE next cycle.
//  - No X propagation: the sigma index is always one of 0..4; unused index decodes to
//    rotation amount 0 (returns x^x^x = x), never X.
// STRUCTURE
//  - Shared package ascon_pkg: ASCON_WORDS=5, WORD_W=64, rotation-amount constant
//    table SIGMA_A[5] / SIGMA_B[5] (6-bit), FSM state typedef {IDLE, RUN, DONE}.
//  - Sub-module ascon_sigma64 (combinational): in x[63:0], idx[2:0] -> y[63:0];
//    barrel rotates built from the package table. Instantiate LANES copies;
//    LANES=1 drives idx from cnt, LANES=5 ties lane k to idx=k.
//  - Top: FSM, 3-bit counter, 5x64 buffer, handshake logic.
// TESTING
//  1. Zero state, LANES=1: load 0 -> out_valid after 5 RUN cycles, out_state=0.
//  2. x0=1, others 0 -> out x0=64'h0000_2010_0000_0001, x1..x4=0.
//  3. x1=1, others 0 -> out x1=64'h0000_0000_0200_0009 (checks 6-bit amount 61).
//  4. Backpressure: out_ready low 10 cycles in DONE -> out_valid/out_state stable,
//     in_ready=0, extra in_valid ignored; release -> in_ready=1 next cycle.
//  5. rst asserted at RUN cnt=2 -> next cycle IDLE, out_valid never pulses, buffer=0.
//  6. Random states, LANES=1 and LANES=5, back-to-back -> match golden model;
//     latency 5 vs 1 cycles exactly.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared constants, types and rotation helper for the Ascon linear diffusion sequencer.
package ascon_pkg;

   localparam int unsigned ASCON_WORDS = 5;
   localparam int unsigned WORD_W      = 64;
   localparam int unsigned ROT_W       = 6;
   localparam int unsigned CNT_W       = 3;

   // Rotate-right amounts per word index (sigma_i uses SIGMA_A[i] and SIGMA_B[i])
   localparam logic [ROT_W-1:0] SIGMA_A [ASCON_WORDS] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
   localparam logic [ROT_W-1:0] SIGMA_B [ASCON_WORDS] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef logic [ASCON_WORDS-1:0][WORD_W-1:0] ascon_state_t;

   // A zero amount yields x, since the left shift by 64 clears to zero
   function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] x,
                                                input logic [ROT_W-1:0]  amt);
      return (x >> amt) | (x << (7'd64 - {1'b0, amt}));
   endfunction

endpackage

// File: rtl/ascon_sigma64.sv
// Combinational sigma unit: y = x ^ ROTR(x,a_idx) ^ ROTR(x,b_idx); idx 5..7 passes x through.
module ascon_sigma64
   import ascon_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [CNT_W-1:0]  idx,
   output logic [WORD_W-1:0] y
);

   logic [ROT_W-1:0] amt_a;
   logic [ROT_W-1:0] amt_b;

   always_comb begin
      amt_a = '0;
      amt_b = '0;
      if (idx < CNT_W'(ASCON_WORDS)) begin
         amt_a = SIGMA_A[idx];
         amt_b = SIGMA_B[idx];
      end
      y = x ^ rotr64(x, amt_a) ^ rotr64(x, amt_b);
   end

endmodule

// File: rtl/ascon_linear_seq.sv
// Ascon linear-layer sequencer: loads a 320-bit state, applies sigma per word using
// LANES shared sigma units, and returns the result over a valid/ready channel.
module ascon_linear_seq
   import ascon_pkg::*;
#(
   parameter int unsigned LANES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ASCON_WORDS*WORD_W-1:0] in_state,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ASCON_WORDS*WORD_W-1:0] out_state,
   output logic                          busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = (LANES == 5) ? CNT_W'(0) : CNT_W'(ASCON_WORDS - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   ascon_state_t      buf_q, buf_d;
   ascon_state_t      run_buf;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   // Datapath: buffer contents after one RUN cycle
   if (LANES == 5) begin : g_par
      for (genvar k = 0; k < ASCON_WORDS; k++) begin : g_lane
         ascon_sigma64 u_sigma (
            .x   (buf_q[k]),
            .idx (CNT_W'(k)),
            .y   (run_buf[k])
         );
      end
   end else begin : g_seq
      logic [CNT_W-1:0]  wsel;
      logic [WORD_W-1:0] lane_y;

      assign wsel = (cnt_q < CNT_W'(ASCON_WORDS)) ? cnt_q : '0;

      ascon_sigma64 u_sigma (
         .x   (buf_q[wsel]),
         .idx (cnt_q),
         .y   (lane_y)
      );

      always_comb begin
         run_buf = buf_q;
         if (cnt_q < CNT_W'(ASCON_WORDS)) run_buf[wsel] = lane_y;
      end
   end

   // Next-state, counter, buffer and registered-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               buf_d   = ascon_state_t'(in_state);
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            buf_d = run_buf;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q >= LAST_CNT) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_state = buf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ascon_linear_seq.sv
// Self-checking bench for ascon_linear_seq with LANES=1 and LANES=5 instances.
module tb_ascon_linear_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic [319:0] in_state;
   logic         in_valid  [2];
   logic         out_ready [2];
   logic         in_ready  [2];
   logic         out_valid [2];
   logic         busy      [2];
   logic [319:0] out_state [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ascon_linear_seq #(.LANES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_state(out_state[0]), .busy(busy[0])
   );

   ascon_linear_seq #(.LANES(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_state(out_state[1]), .busy(busy[1])
   );

   // Reference model: sigma_i from the rotation table, rotation via a doubled word
   function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n);
      logic [127:0] t;
      t = {x, x} >> n;
      return t[63:0];
   endfunction

   function automatic logic [319:0] ref_linear(input logic [319:0] s);
      int ra [5] = '{19, 61, 1, 10, 7};
      int rb [5] = '{28, 39, 6, 17, 41};
      logic [319:0] r;
      logic [63:0]  x;
      for (int i = 0; i < 5; i++) begin
         x = s[64*i +: 64];
         r[64*i +: 64] = x ^ ref_rotr(x, ra[i]) ^ ref_rotr(x, rb[i]);
      end
      return r;
   endfunction

   function automatic logic [319:0] rand_state();
      logic [319:0] s;
      for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load one state into DUT d, measure latency, check result, hand it off
   task automatic run_one(input int d, input logic [319:0] s, input string name);
      int lat;
      int exp_lat;
      logic [319:0] exp;
      exp     = ref_linear(s);
      exp_lat = (d == 0) ? 5 : 1;
      n_checks++;
      if (in_ready[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready before load: got %b want 1", name, in_ready[d]);
      end
      in_state    = s;
      in_valid[d] = 1'b1;
      step();
      in_valid[d] = 1'b0;
      lat = 0;
      while (out_valid[d] !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (out_state[d] !== exp) begin
         n_fail++;
         $display("FAIL %s out_state: got %h want %h", name, out_state[d], exp);
      end
      out_ready[d] = 1'b1;
      step();
      out_ready[d] = 1'b0;
      n_checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s handoff: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                  name, out_valid[d], in_ready[d], busy[d]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready[%0d]: got %b want 1", d, in_ready[d]);
         end
         n_checks++;
         if (out_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid[%0d]: got %b want 0", d, out_valid[d]);
         end
         n_checks++;
         if (busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy[%0d]: got %b want 0", d, busy[d]);
         end
         n_checks++;
         if (out_state[d] !== 320'd0) begin
            n_fail++;
            $display("FAIL reset out_state[%0d]: got %h want 0", d, out_state[d]);
         end
      end
   endtask

   task automatic test_zero();
      run_one(0, 320'd0, "zero");
   endtask

   // Single-bit words with literal expectations, independent of the model
   task automatic test_unit_words();
      logic [319:0] s;
      logic [319:0] exp;
      s   = 320'd0;
      exp = 320'd0;
      s[0]       = 1'b1;
      exp[63:0]  = 64'h0000_2010_0000_0001;
      run_one(0, s, "unit_x0");
      n_checks++;
      if (dut1.out_state !== exp) begin
         n_fail++;
         $display("FAIL unit_x0 literal: got %h want %h", dut1.out_state, exp);
      end
      s   = 320'd0;
      exp = 320'd0;
      s[64]        = 1'b1;
      exp[127:64]  = 64'h0000_0000_0200_0009;
      run_one(0, s, "unit_x1");
      n_checks++;
      if (dut1.out_state !== exp) begin
         n_fail++;
         $display("FAIL unit_x1 literal: got %h want %h", dut1.out_state, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [319:0] s;
      logic [319:0] exp;
      int           n;
      s   = rand_state();
      exp = ref_linear(s);
      in_state    = s;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      n = 0;
      while (out_valid[0] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      in_state    = rand_state();
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (out_valid[0] !== 1'b1 || out_state[0] !== exp || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b out_state=%h want 1 0 %h",
                     i, out_valid[0], in_ready[0], out_state[0], exp);
         end
         step();
      end
      out_ready[0] = 1'b1;
      step();
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure release: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                  in_ready[0], out_valid[0], busy[0]);
      end
      step();
      n_checks++;
      if (busy[0] !== 1'b0 || out_state[0] !== exp) begin
         n_fail++;
         $display("FAIL backpressure no-capture: busy=%b out_state=%h want 0 %h",
                  busy[0], out_state[0], exp);
      end
   endtask

   task automatic test_reset_mid_run();
      int seen_valid;
      in_state    = rand_state();
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
          out_state[0] !== 320'd0) begin
         n_fail++;
         $display("FAIL reset_mid_run: in_ready=%b out_valid=%b busy=%b out_state=%h want 1 0 0 0",
                  in_ready[0], out_valid[0], busy[0], out_state[0]);
      end
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid[0] === 1'b1) seen_valid++;
      end
      n_checks++;
      if (seen_valid != 0) begin
         n_fail++;
         $display("FAIL reset_mid_run pulse: out_valid seen %0d cycles want 0", seen_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            run_one(d, rand_state(), (d == 0) ? "random_lanes1" : "random_lanes5");
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      in_state     = '0;
      in_valid[0]  = 1'b0;
      in_valid[1]  = 1'b0;
      out_ready[0] = 1'b0;
      out_ready[1] = 1'b0;
      test_reset();
      test_zero();
      test_unit_words();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
